// File: rtl/axi_mem_pkg.sv
// -----------------------------------------------------------------------------
// axi_mem_pkg
// Shared types and constants for the AXI4-Lite responder (axi_mem_ctrl) that
// fronts a 128-byte memory which updates on the falling clock edge.
//   state_e        : controller FSM states
//   RESP_OKAY/SLVERR : AXI response encodings
//   MEM_BYTES, MEM_AW, MAX_BYTE_ADDR : memory geometry; the highest legal
//                    start address leaves room for a full 4-byte word
//   addr_legal()   : range check shared by the read and write paths
// -----------------------------------------------------------------------------
package axi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    WR_RESP,
    RD_ISSUE,
    RD_CAPT,
    RD_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned MEM_BYTES = 128;
  localparam int unsigned MEM_AW    = $clog2(MEM_BYTES);

  // Last start address whose 4-byte word still fits inside the memory.
  localparam logic [MEM_AW-1:0] MAX_BYTE_ADDR = MEM_AW'(124);

  // An address is legal when it lies inside the memory and a whole word can
  // be taken from it without running off the end.
  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr[31:MEM_AW] == '0) && (addr[MEM_AW-1:0] <= MAX_BYTE_ADDR);
  endfunction

endpackage

// File: rtl/axi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// axi_mem_ctrl
// AXI4-Lite responder for a 128-byte memory that reads and writes on the
// falling clock edge. One transaction is in flight at a time; a write that is
// ready in the same cycle as a read is served first.
//
// Ports
//   CLK, RST                 clock (posedge), asynchronous active-high reset
//   AW*/W*/B*                AXI4-Lite write address, data and response
//   AR*/R*                   AXI4-Lite read address and data/response
//   CS, WE                   memory select / write enable (one cycle pulses)
//   WADDR, RADDR             memory byte addresses for write / read
//   Mem_in, Mem_out          memory write data / read data (little-endian)
//   writefinish              memory signals that a write has completed
//
// Parameter
//   TIMEOUT                  cycles to wait for writefinish before SLVERR
//
// Configuration macro
//   MEMCTRL_ALIGN_CHECK_EN   when defined, addresses with ADDR[1:0] != 0 are
//                            rejected with SLVERR and never reach memory;
//                            otherwise they are accessed at the byte address.
// -----------------------------------------------------------------------------
module axi_mem_ctrl
  import axi_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [31:0]       ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              CS,
  output logic              WE,
  output logic [MEM_AW-1:0] WADDR,
  output logic [MEM_AW-1:0] RADDR,
  output logic [31:0]       Mem_in,
  input  logic [31:0]       Mem_out,
  input  logic              writefinish
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e              state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [MEM_AW-1:0]   waddr_q,  waddr_d;
  logic [MEM_AW-1:0]   raddr_q,  raddr_d;
  logic [31:0]         mem_in_q, mem_in_d;
  logic [31:0]         rdata_q,  rdata_d;
  logic [1:0]          bresp_q,  bresp_d;
  logic [1:0]          rresp_q,  rresp_d;

  logic wr_legal;
  logic rd_legal;
  logic aw_hs;
  logic ar_hs;

`ifdef MEMCTRL_ALIGN_CHECK_EN
  assign wr_legal = addr_legal(AWADDR) && (AWADDR[1:0] == 2'b00);
  assign rd_legal = addr_legal(ARADDR) && (ARADDR[1:0] == 2'b00);
`else
  assign wr_legal = addr_legal(AWADDR);
  assign rd_legal = addr_legal(ARADDR);
`endif

  // Ready is offered only in IDLE, only for a complete AW+W pair, and the
  // write pair always beats a simultaneous read. RST gates the readies so
  // every output reads 0 while reset is held, whatever the master drives.
  assign aw_hs = (state_q == IDLE) && AWVALID && WVALID && !RST;
  assign ar_hs = (state_q == IDLE) && ARVALID && !(AWVALID && WVALID) && !RST;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    mem_in_d = mem_in_q;
    rdata_d  = rdata_q;
    bresp_d  = bresp_q;
    rresp_d  = rresp_q;

    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          waddr_d  = AWADDR[MEM_AW-1:0];
          mem_in_d = WDATA;
          if (wr_legal) begin
            state_d = WR_ISSUE;
          end else begin
            bresp_d = RESP_SLVERR;
            state_d = WR_RESP;
          end
        end else if (ar_hs) begin
          raddr_d = ARADDR[MEM_AW-1:0];
          if (rd_legal) begin
            state_d = RD_ISSUE;
          end else begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
            state_d = RD_RESP;
          end
        end
      end

      WR_ISSUE: begin
        cnt_d   = '0;
        state_d = WR_WAIT;
      end

      // The counter reaches TIMEOUT-1 on the TIMEOUT-th cycle spent here, so
      // the error response leaves exactly TIMEOUT cycles after entry.
      WR_WAIT: begin
        if (writefinish) begin
          bresp_d = RESP_OKAY;
          cnt_d   = '0;
          state_d = WR_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          bresp_d = RESP_SLVERR;
          cnt_d   = '0;
          state_d = WR_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR_RESP: begin
        if (BREADY) state_d = IDLE;
      end

      RD_ISSUE: begin
        state_d = RD_CAPT;
      end

      // Mem_out was refreshed on the falling edge inside RD_ISSUE and RADDR is
      // still held, so the word is stable for capture here.
      RD_CAPT: begin
        rdata_d = Mem_out;
        rresp_d = RESP_OKAY;
        state_d = RD_RESP;
      end

      RD_RESP: begin
        if (RREADY) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values of the others, and reset clears them asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      mem_in_q <= '0;
      rdata_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      mem_in_q <= mem_in_d;
      rdata_q  <= rdata_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
    end
  end

  assign AWREADY = aw_hs;
  assign WREADY  = aw_hs;
  assign ARREADY = ar_hs;
  assign BVALID  = (state_q == WR_RESP);
  assign RVALID  = (state_q == RD_RESP);
  assign BRESP   = bresp_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign CS      = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
  assign WE      = (state_q == WR_ISSUE);
  assign WADDR   = waddr_q;
  assign RADDR   = raddr_q;
  assign Mem_in  = mem_in_q;

endmodule

// File: tb/tb_axi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_ctrl
// Directed bench for axi_mem_ctrl. A behavioural 128-byte memory (preloaded
// with mem[i] = i, updated on the falling edge) answers the controller; a
// write raises writefinish one cycle after the write strobe unless wf_en is
// cleared. Outputs are sampled on the falling edge or 1 time unit after the
// rising edge. Latency figures count falling edges after the handshake edge.
// -----------------------------------------------------------------------------
module tb_axi_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic        AWVALID, WVALID, ARVALID, BREADY, RREADY;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic        CS, WE;
  logic [6:0]  WADDR, RADDR;
  logic [31:0] Mem_in;
  logic [31:0] Mem_out     = '0;
  logic        writefinish = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  axi_mem_ctrl #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .CS(CS), .WE(WE), .WADDR(WADDR), .RADDR(RADDR),
    .Mem_in(Mem_in), .Mem_out(Mem_out), .writefinish(writefinish)
  );

  always #5 CLK = ~CLK;

  // ---------------- memory model and activity monitor ----------------
  logic [7:0] mem [128];
  logic       loaded  = 1'b0;
  logic       wf_pend = 1'b0;
  logic       wf_en;
  int         cs_cnt    = 0;
  int         cs_we_cnt = 0;

  always @(negedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
      loaded <= 1'b1;
    end else begin
      if (CS && WE) begin
        mem[WADDR]        <= Mem_in[7:0];
        mem[WADDR + 7'd1] <= Mem_in[15:8];
        mem[WADDR + 7'd2] <= Mem_in[23:16];
        mem[WADDR + 7'd3] <= Mem_in[31:24];
      end
      if (CS && !WE)
        Mem_out <= {mem[RADDR + 7'd3], mem[RADDR + 7'd2], mem[RADDR + 7'd1], mem[RADDR]};
    end
    writefinish <= wf_pend && wf_en;
    wf_pend     <= CS && WE;
    if (CS)       cs_cnt    <= cs_cnt + 1;
    if (CS && WE) cs_we_cnt <= cs_we_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_hs_valid"}, 32'({AWREADY, WREADY, ARREADY, BVALID, RVALID, CS, WE}), 32'h0);
    check({pfx, "_bresp_rresp"}, 32'({BRESP, RRESP}), 32'h0);
    check({pfx, "_rdata"}, RDATA, 32'h0);
    check({pfx, "_waddr_raddr"}, 32'({WADDR, RADDR}), 32'h0);
    check({pfx, "_mem_in"}, Mem_in, 32'h0);
  endtask

  // Waits (bounded) for AWREADY&WREADY, then lets the handshake edge pass.
  task automatic wait_aw_hs(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (AWREADY && WREADY) begin ok = 1'b1; break; end
      @(negedge CLK); #1;
    end
    check({tag, "_aw_hs"}, 32'(ok), 32'h1);
    @(posedge CLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  task automatic wait_ar_hs(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ARREADY) begin ok = 1'b1; break; end
      @(negedge CLK); #1;
    end
    check({tag, "_ar_hs"}, 32'(ok), 32'h1);
    @(posedge CLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic aw_w(input string tag, input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    wait_aw_hs(tag);
  endtask

  task automatic ar(input string tag, input logic [31:0] a);
    @(negedge CLK);
    ARADDR = a; ARVALID = 1'b1;
    #1;
    wait_ar_hs(tag);
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge CLK); lat++;
      if (BVALID) break;
    end
  endtask

  task automatic wait_r(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge CLK); lat++;
      if (RVALID) break;
    end
  endtask

  task automatic accept_b;
    BREADY = 1'b1; @(posedge CLK); #1; BREADY = 1'b0;
  endtask

  task automatic accept_r;
    RREADY = 1'b1; @(posedge CLK); #1; RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   lat;
    int   base_cs, base_cs_we;
    logic stable, b_seen;

    RST = 1'b1; wf_en = 1'b1;
    AWADDR = '0; WDATA = '0; ARADDR = '0;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    BREADY = 1'b0; RREADY = 1'b0;

    // Reset state.
    repeat (3) @(negedge CLK);
    check_all_zero("in_reset");
    RST = 1'b0;
    @(negedge CLK);
    check_all_zero("after_reset");

    // Read word 0 from the preloaded memory: 3-cycle latency.
    ar("rd0", 32'h0);
    wait_r(lat);
    check("rd0_latency", 32'(lat), 32'd3);
    check("rd0_rdata", RDATA, 32'h0302_0100);
    check("rd0_rresp", 32'(RRESP), 32'(2'b00));
    accept_r();

    // Write then read back 0x10; exactly one CS&WE cycle for the write.
    base_cs_we = cs_we_cnt;
    aw_w("wr10", 32'h10, 32'hDEAD_BEEF);
    wait_b(lat);
    check("wr10_latency", 32'(lat), 32'd3);
    check("wr10_bresp", 32'(BRESP), 32'(2'b00));
    accept_b();
    check("wr10_cs_we_cycles", 32'(cs_we_cnt - base_cs_we), 32'd1);
    ar("rd10", 32'h10);
    wait_r(lat);
    check("rd10_rdata", RDATA, 32'hDEAD_BEEF);
    check("rd10_rresp", 32'(RRESP), 32'(2'b00));
    accept_r();

    // Illegal addresses: SLVERR straight away, memory untouched.
    base_cs = cs_cnt;
    aw_w("wr7e", 32'h7E, 32'h1111_2222);
    wait_b(lat);
    check("wr7e_latency", 32'(lat), 32'd1);
    check("wr7e_bresp", 32'(BRESP), 32'(2'b10));
    accept_b();
    ar("rd80", 32'h80);
    wait_r(lat);
    check("rd80_latency", 32'(lat), 32'd1);
    check("rd80_rresp", 32'(RRESP), 32'(2'b10));
    check("rd80_rdata", RDATA, 32'h0);
    accept_r();
    ar("rd7d", 32'h7D);
    wait_r(lat);
    check("rd7d_rresp", 32'(RRESP), 32'(2'b10));
    accept_r();
    check("illegal_cs_cycles", 32'(cs_cnt - base_cs), 32'd0);

    // Highest legal address reads the last four bytes.
    ar("rd7c", 32'h7C);
    wait_r(lat);
    check("rd7c_rdata", RDATA, 32'h7F7E_7D7C);
    check("rd7c_rresp", 32'(RRESP), 32'(2'b00));
    accept_r();

    // writefinish tied low: SLVERR 4 cycles after WR_WAIT entry
    // (1 edge to WR_ISSUE->WR_WAIT, 4 in WR_WAIT, counted from the handshake: 6).
    wf_en = 1'b0;
    aw_w("wr_to", 32'h30, 32'hCAFE_F00D);
    wait_b(lat);
    check("timeout_latency", 32'(lat), 32'd6);
    check("timeout_bresp", 32'(BRESP), 32'(2'b10));
    accept_b();
    wf_en = 1'b1;

    // Write and read offered together: write wins, both stall 5 cycles.
    @(negedge CLK);
    AWADDR = 32'h20; WDATA = 32'h1234_5678; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 32'h20; ARVALID = 1'b1;
    #1;
    check("both_awready", 32'(AWREADY), 32'h1);
    check("both_arready", 32'(ARREADY), 32'h0);
    wait_aw_hs("both_wr");
    wait_b(lat);
    check("both_b_latency", 32'(lat), 32'd3);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (!(BVALID && BRESP == 2'b00 && !ARREADY && !RVALID)) stable = 1'b0;
    end
    check("b_stall_stable", 32'(stable), 32'h1);
    accept_b();
    wait_ar_hs("both_rd");
    wait_r(lat);
    check("both_r_latency", 32'(lat), 32'd3);
    check("both_rdata_new", RDATA, 32'h1234_5678);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (!(RVALID && RDATA == 32'h1234_5678 && RRESP == 2'b00)) stable = 1'b0;
    end
    check("r_stall_stable", 32'(stable), 32'h1);
    accept_r();

    // Reset pulse while waiting for writefinish: no response afterwards.
    wf_en = 1'b0;
    aw_w("wr_rst", 32'h40, 32'hA5A5_A5A5);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge CLK);
    RST = 1'b0;
    b_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (BVALID) b_seen = 1'b1;
    end
    check("no_b_after_reset", 32'(b_seen), 32'h0);
    check_all_zero("post_abort");
    wf_en = 1'b1;

    // Unaligned read at 0x02.
    ar("rd02", 32'h02);
    wait_r(lat);
`ifdef MEMCTRL_ALIGN_CHECK_EN
    check("rd02_latency", 32'(lat), 32'd1);
    check("rd02_rresp", 32'(RRESP), 32'(2'b10));
    check("rd02_rdata", RDATA, 32'h0);
`else
    check("rd02_latency", 32'(lat), 32'd3);
    check("rd02_rresp", 32'(RRESP), 32'(2'b00));
    check("rd02_rdata", RDATA, 32'h0504_0302);
`endif
    accept_r();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
